// File: rtl/serial_ripple_subtractor_if.sv
// Operand request / result handshake bundle for the bit-serial subtractor.
// The master drives the operands and out_ready. The slave (the subtractor) drives the result.
interface serial_ripple_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// The result and flags are held in registers until the next operation completes.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  serial_ripple_subtractor_if.slave      bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             br;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q, zero_q;

  logic             a_bit, b_bit, d_bit, br_nx;
  logic             last_bit;
  logic [WIDTH-1:0] sr_nx;
  logic             ovf_nx;

  // Per-bit full-subtractor slice on the captured operands.
  always_comb begin
    a_bit    = a_q[cnt];
    b_bit    = b_q[cnt];
    d_bit    = a_bit ^ b_bit ^ br;
    br_nx    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    sr_nx    = d_sr;
    sr_nx[cnt] = d_bit;
    ovf_nx   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sr_nx[WIDTH-1] ^ a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br     <= 1'b0;
      d_sr   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
            d_sr <= '0;
          end
        end
        RUN: begin
          br   <= br_nx;
          d_sr <= sr_nx;
          // The counter stops at WIDTH-1 so it never wraps; capture clears it.
          if (last_bit) begin
            diff_q <= sr_nx;
            bout_q <= br_nx;
            ovf_q  <= ovf_nx;
            zero_q <= (sr_nx == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and random checks of the bit-serial subtractor against an arithmetic model.
module tb_serial_ripple_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } res_t;

  res_t exp_q[$];
  res_t last_res = '0;
  int   total = 0;
  int   bad = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    res_t       r;
    t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    r.d  = t[W-1:0];
    r.bo = t[W];
    r.ov = (a[W-1] ^ b[W-1]) & (r.d[W-1] ^ a[W-1]);
    r.z  = (r.d == '0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(e.d));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(e.bo));
    chk({tag, "_ovf"},  32'(bus.ovf),  32'(e.ov));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(e.z));
  endtask

  task automatic drive_junk();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bin      = 1'($urandom_range(0, 1));
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge after the result handshake.
  // With nxt_v set, the next operands are presented with in_valid=1 through the stall and handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int stall, input bit chaos,
                       input bit nxt_v, input logic [W-1:0] na, input logic [W-1:0] nb,
                       input logic nbin);
    int   lat;
    res_t e;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    @(posedge clk);
    exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    if (chaos) drive_junk(); else bus.in_valid = 1'b0;
    chk("in_ready_run", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (lat < 40) begin
      if (chaos) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (bus.out_valid) break;
      chk("hold_run_diff", 32'(bus.diff), 32'(last_res.d));
      if (chaos) drive_junk();
    end
    chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
    chk("latency", 32'(lat), 32'(W));
    if (bus.out_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_res("result", e);
      last_res = e;
      for (int i = 0; i < stall; i++) begin
        if (nxt_v) begin
          bus.in_valid = 1'b1; bus.a = na; bus.b = nb; bus.bin = nbin;
        end else if (chaos) begin
          drive_junk();
        end
        @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk_res("stall", e);
      end
      if (nxt_v) begin
        bus.in_valid = 1'b1; bus.a = na; bus.b = nb; bus.bin = nbin;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk_res("post_hs_hold", e);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_res("rst", '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, borrow and overflow cases.
    do_op(8'h50, 8'h20, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset three edges into RUN discards the operation.
    bus.in_valid = 1'b1; bus.a = 8'h37; bus.b = 8'h11; bus.bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_res("midrun_rst", '0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(bus.out_valid), 32'd0);
    end
    do_op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    do_op(8'h00, 8'h01, 1'b0, 1, 1'b0, 1'b0, '0, '0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    do_op(8'h05, 8'h04, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    do_op(8'h7F, 8'h80, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Backpressure with a pending request held across the handshake.
    do_op(8'hC3, 8'h5A, 1'b1, 5, 1'b0, 1'b1, 8'h21, 8'h42, 1'b0);
    do_op(8'h21, 8'h42, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Random regression with stalls and junk on the inputs while busy.
    for (int n = 0; n < 1500; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'b1, 1'b0, '0, '0, 1'b0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
